// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared types and helpers for the 8-way round-robin mux scheduler.
package mux8_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Pointer to the requester after sel; the 3-bit add wraps 7 -> 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
        return sel + 3'd1;
    endfunction

endpackage

// File: rtl/mux8_rr_scheduler_if.sv
// Request/grant/handshake bundle between the scheduler and its requesters plus consumer.
interface mux8_rr_scheduler_if;
    import mux8_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic [SEL_W-1:0] s;
    logic [N_REQ-1:0] gnt;
    logic             out_valid;
    logic             timeout_err;

    modport master (
        input  req, out_ready,
        output s, gnt, out_valid, timeout_err
    );

    modport slave (
        output req, out_ready,
        input  s, gnt, out_valid, timeout_err
    );
endinterface

// File: rtl/mux8_rr_scheduler_pick.sv
// Combinational rotating-priority encoder: first set req at or after ptr, wrapping.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        any   = |req;
        win   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux among 8 requesters with bounded bursts.
// Optional stall timeout enabled by defining MUX8_SCHED_TIMEOUT_EN.
module mux8_rr_scheduler
    import mux8_sched_pkg::*;
#(
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mux8_rr_scheduler_if.master   bus
);

    if (BURST < 1 || BURST > 15) begin : g_bad_burst
        $error("BURST out of range");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range");
    end

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [SEL_W-1:0] pick_ptr;
    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             beat;
    logic             end_burst;
    logic             req_drop;
    logic             tmo_hit;
    logic             release_gnt;

    // While granted, the next owner is searched from just past the current one.
    assign pick_ptr    = (state == S_GRANT) ? next_ptr(bus.s) : ptr;
    assign beat        = bus.out_valid & bus.out_ready;
    assign end_burst   = beat && (beat_cnt == CNT_W'(BURST - 1));
    assign req_drop    = !bus.req[bus.s];
    assign release_gnt = (state == S_GRANT) && (end_burst || req_drop || tmo_hit);

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .any (pick_any),
        .win (pick_win)
    );

`ifdef MUX8_SCHED_TIMEOUT_EN
    logic [7:0] stall_cnt;

    assign tmo_hit = (state == S_GRANT) && !bus.out_ready
                     && (stall_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt       <= 8'd0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.timeout_err <= tmo_hit;
            if (state != S_GRANT || bus.out_ready || release_gnt)
                stall_cnt <= 8'd0;
            else
                stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ptr           <= '0;
            beat_cnt      <= '0;
            bus.s         <= '0;
            bus.gnt       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        state         <= S_GRANT;
                        bus.s         <= pick_win;
                        bus.gnt       <= N_REQ'(1) << pick_win;
                        bus.out_valid <= 1'b1;
                        beat_cnt      <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_gnt) begin
                        ptr      <= next_ptr(bus.s);
                        beat_cnt <= '0;
                        // Hand over at the same edge so the next owner sees no bubble.
                        if (pick_any) begin
                            bus.s   <= pick_win;
                            bus.gnt <= N_REQ'(1) << pick_win;
                        end else begin
                            state         <= S_IDLE;
                            bus.gnt       <= '0;
                            bus.out_valid <= 1'b0;
                        end
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Randomized and directed bench for mux8_rr_scheduler against a queue-free behavioural model.
module tb_mux8_rr_scheduler;

    localparam int BURST   = 4;
    localparam int TIMEOUT = 16;
`ifdef MUX8_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] i_data;
    logic       y;
    int         checks;
    int         errors;

    mux8_rr_scheduler_if bus ();

    mux8_rr_scheduler #(.BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The shared mux the scheduler steers.
    assign y = i_data[bus.s];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the mux, how many beats and stalls it has had so far.
    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_beats;
    int m_stalls;
    bit m_tmo;

    function automatic int pickFrom(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++)
            if (r[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    task automatic resetModel();
        m_valid  = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_beats  = 0;
        m_stalls = 0;
        m_tmo    = 1'b0;
    endtask

    task automatic stepModel(input logic [7:0] r, input bit rdy);
        int w;
        bit done;
        m_tmo = 1'b0;
        if (!m_valid) begin
            w = pickFrom(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1'b1;
                m_owner = w;
                m_beats = 0;
                m_stalls = 0;
            end
        end else begin
            if (rdy) begin
                m_beats++;
                m_stalls = 0;
            end else begin
                m_stalls++;
            end
            m_tmo = TO_EN && !rdy && (m_stalls == TIMEOUT);
            done  = (m_beats == BURST) || !r[m_owner] || m_tmo;
            if (done) begin
                m_ptr    = (m_owner + 1) % 8;
                m_beats  = 0;
                m_stalls = 0;
                w = pickFrom(r, m_ptr);
                if (w < 0) m_valid = 1'b0;
                else       m_owner = w;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic [7:0] exp_gnt;
        exp_gnt = m_valid ? (8'd1 << m_owner) : 8'd0;
        checkOutput("s",           32'(bus.s),           32'(m_owner));
        checkOutput("gnt",         32'(bus.gnt),         32'(exp_gnt));
        checkOutput("out_valid",   32'(bus.out_valid),   32'(m_valid));
        checkOutput("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
        checkOutput("onehot0",     32'($onehot0(bus.gnt)), 32'd1);
        checkOutput("valid_vs_or", 32'(bus.out_valid),   32'(|bus.gnt));
        checkOutput("gnt_at_s",    32'(bus.gnt[bus.s]),  32'(bus.out_valid));
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, check 1 ns later.
    task automatic applyStimulus(input logic [7:0] r, input bit rdy);
        @(negedge clk);
        bus.req       = r;
        bus.out_ready = rdy;
        i_data        = 8'($urandom);
        @(posedge clk);
        if (m_valid && rdy)
            checkOutput("y_on_beat", 32'(y), 32'(i_data[m_owner]));
        stepModel(r, rdy);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst           = 1'b1;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("rst_s",   32'(bus.s),         32'd0);
        checkOutput("rst_gnt", 32'(bus.gnt),       32'd0);
        checkOutput("rst_ov",  32'(bus.out_valid), 32'd0);
        checkOutput("rst_te",  32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        i_data = 8'h00;
        resetModel();
        repeat (2) @(posedge clk);

        $display("[TB] single requester bursts");
        doReset();
        applyStimulus(8'h01, 1'b1);
        checkOutput("first_gnt", 32'(bus.gnt), 32'h01);
        repeat (10) applyStimulus(8'h01, 1'b1);
        checkOutput("regrant_gnt", 32'(bus.gnt), 32'h01);

        $display("[TB] all requesting, full rotation");
        doReset();
        repeat (40) applyStimulus(8'hFF, 1'b1);

        $display("[TB] drop of granted req while stalled");
        doReset();
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h14, 1'b0);
        applyStimulus(8'h10, 1'b0);
        checkOutput("drop_moves", 32'(bus.gnt), 32'h10);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);

        $display("[TB] rotation from ptr 4, then reset mid-burst");
        doReset();
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h88, 1'b1);
        checkOutput("ptr4_wins7", 32'(bus.gnt), 32'h80);
        applyStimulus(8'h88, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_s",   32'(bus.s),         32'd0);
        checkOutput("async_gnt", 32'(bus.gnt),       32'd0);
        checkOutput("async_ov",  32'(bus.out_valid), 32'd0);
        resetModel();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] consumer stalled for 100 cycles");
        doReset();
        repeat (100) applyStimulus(8'h01, 1'b0);
`ifndef MUX8_SCHED_TIMEOUT_EN
        checkOutput("hold_gnt", 32'(bus.gnt), 32'h01);
`endif

        $display("[TB] randomized traffic");
        doReset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            applyStimulus(r, ($urandom_range(0, 3) != 0));
        end
        for (int n = 0; n < 300; n++)
            applyStimulus(8'($urandom), ($urandom_range(0, 9) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
